// File: rtl/regfile_param_if.sv
// Bus bundle for regfile_param: two read ports, two write ports, debug read
// and the clear-sweep handshake.
interface regfile_param_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AW     = 5
);

  logic [AW-1:0]     rs_addr;
  logic [AW-1:0]     rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;

  logic              wa_en;
  logic [AW-1:0]     wa_addr;
  logic [DATA_W-1:0] wa_data;
  logic              wb_en;
  logic [AW-1:0]     wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic [AW-1:0]     du_addr;
  logic [DATA_W-1:0] du_data;

  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;

  modport master (
    output rs_addr, rt_addr, wa_en, wa_addr, wa_data,
           wb_en, wb_addr, wb_data, du_addr, clr_req,
    input  rs_data, rt_data, du_data, clr_busy, clr_done
  );

  modport slave (
    input  rs_addr, rt_addr, wa_en, wa_addr, wa_data,
           wb_en, wb_addr, wb_data, du_addr, clr_req,
    output rs_data, rt_data, du_data, clr_busy, clr_done
  );

endinterface

// File: rtl/regfile_param.sv
// Parameterised 2R/2W register file with optional zero register, write bypass,
// a debug read port and a one-register-per-cycle clear sweep.
module regfile_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned AW       = $clog2(NREGS),
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic            clk,
  input  logic            reset,
  regfile_param_if.slave  bus
);

  localparam bit            ZERO_EN  = (ZERO_REG != 0);
  localparam bit            BYP_EN   = (BYPASS != 0);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e            state;
  logic [AW-1:0]     idx;
  logic              clr_busy_q;
  logic              clr_done_q;
  logic [DATA_W-1:0] mem [NREGS];

  logic              idle_c;
  logic              wa_ok_c;
  logic              wb_ok_c;

  // A write is live only in IDLE and never when it targets a hardwired zero register.
  assign idle_c  = (state == IDLE);
  assign wa_ok_c = bus.wa_en && idle_c && !(ZERO_EN && (bus.wa_addr == '0));
  assign wb_ok_c = bus.wb_en && idle_c && !(ZERO_EN && (bus.wb_addr == '0));

  // Clear FSM; busy/done are registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clr_done_q <= 1'b0;
          if (bus.clr_req) begin
            state      <= SWEEP;
            idx        <= '0;
            clr_busy_q <= 1'b1;
          end
        end
        SWEEP: begin
          if (idx == LAST_IDX) begin
            state      <= DONE;
            clr_done_q <= 1'b1;
          end else begin
            idx <= idx + AW'(1);
          end
        end
        DONE: begin
          state      <= IDLE;
          clr_busy_q <= 1'b0;
          clr_done_q <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          idx        <= '0;
          clr_busy_q <= 1'b0;
          clr_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage: sweep zeroes one entry per cycle; otherwise port B is written last so it wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem <= '{default: '0};
    end else if (state == SWEEP) begin
      mem[idx] <= '0;
    end else begin
      if (wa_ok_c) mem[bus.wa_addr] <= bus.wa_data;
      if (wb_ok_c) mem[bus.wb_addr] <= bus.wb_data;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [AW-1:0] addr);
    logic [DATA_W-1:0] val;
    val = mem[addr];
    if (BYP_EN && wa_ok_c && (bus.wa_addr == addr)) val = bus.wa_data;
    if (BYP_EN && wb_ok_c && (bus.wb_addr == addr)) val = bus.wb_data;
    if (ZERO_EN && (addr == '0)) val = '0;
    return val;
  endfunction

  always_comb begin
    bus.rs_data = read_port(bus.rs_addr);
    bus.rt_data = read_port(bus.rt_addr);
  end

  // Debug port sees stored contents only.
  always_comb begin
    bus.du_data = mem[bus.du_addr];
    if (ZERO_EN && (bus.du_addr == '0)) bus.du_data = '0;
  end

  assign bus.clr_busy = clr_busy_q;
  assign bus.clr_done = clr_done_q;

endmodule

// File: tb/tb_regfile_param.sv
// Randomised and directed checks of regfile_param (BYPASS=1 and BYPASS=0 copies)
// against an array-based reference model.
module tb_regfile_param;

  localparam int unsigned NREGS  = 32;
  localparam int unsigned AW     = 5;
  localparam int unsigned DATA_W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic [AW-1:0]     rs_addr, rt_addr, du_addr, wa_addr, wb_addr;
  logic [DATA_W-1:0] wa_data, wb_data;
  logic              wa_en, wb_en, clr_req;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: register contents and cycles elapsed since a clear request
  // (0 = idle, 1..NREGS = sweeping, NREGS+1 = done cycle).
  logic [DATA_W-1:0] m [NREGS];
  int                k;
  logic              last_busy, last_done;

  regfile_param_if #(.DATA_W(DATA_W), .AW(AW)) bus_a ();
  regfile_param_if #(.DATA_W(DATA_W), .AW(AW)) bus_b ();

  regfile_param u_dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_a)
  );

  regfile_param #(.BYPASS(0)) u_dut_nb (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_b)
  );

  assign bus_a.rs_addr = rs_addr;  assign bus_b.rs_addr = rs_addr;
  assign bus_a.rt_addr = rt_addr;  assign bus_b.rt_addr = rt_addr;
  assign bus_a.du_addr = du_addr;  assign bus_b.du_addr = du_addr;
  assign bus_a.wa_en   = wa_en;    assign bus_b.wa_en   = wa_en;
  assign bus_a.wa_addr = wa_addr;  assign bus_b.wa_addr = wa_addr;
  assign bus_a.wa_data = wa_data;  assign bus_b.wa_data = wa_data;
  assign bus_a.wb_en   = wb_en;    assign bus_b.wb_en   = wb_en;
  assign bus_a.wb_addr = wb_addr;  assign bus_b.wb_addr = wb_addr;
  assign bus_a.wb_data = wb_data;  assign bus_b.wb_data = wb_data;
  assign bus_a.clr_req = clr_req;  assign bus_b.clr_req = clr_req;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_read(input logic [AW-1:0] addr, input bit byp);
    if (addr == 0) return '0;
    if (byp && k == 0) begin
      if (wb_en && wb_addr == addr) return wb_data;
      if (wa_en && wa_addr == addr) return wa_data;
    end
    return m[addr];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m[i] = '0;
    k = 0;
  endtask

  // Reference behaviour at one rising edge.
  task automatic model_edge();
    if (k == 0) begin
      if (wa_en && wa_addr != 0) m[wa_addr] = wa_data;
      if (wb_en && wb_addr != 0) m[wb_addr] = wb_data;
      if (clr_req) k = 1;
    end else if (k <= NREGS) begin
      m[AW'(k - 1)] = '0;
      k++;
    end else begin
      k = 0;
    end
  endtask

  task automatic idle_inputs();
    wa_en = 1'b0; wb_en = 1'b0; clr_req = 1'b0;
    wa_addr = '0; wb_addr = '0; wa_data = '0; wb_data = '0;
  endtask

  // One clock cycle: check all outputs mid-cycle, then advance DUT and model together.
  task automatic step();
    #1;
    check("rs_a",   bus_a.rs_data, exp_read(rs_addr, 1'b1));
    check("rt_a",   bus_a.rt_data, exp_read(rt_addr, 1'b1));
    check("du_a",   bus_a.du_data, exp_read(du_addr, 1'b0));
    check("rs_b",   bus_b.rs_data, exp_read(rs_addr, 1'b0));
    check("rt_b",   bus_b.rt_data, exp_read(rt_addr, 1'b0));
    check("du_b",   bus_b.du_data, exp_read(du_addr, 1'b0));
    check("busy_a", 32'(bus_a.clr_busy), 32'(k != 0));
    check("done_a", 32'(bus_a.clr_done), 32'(k == NREGS + 1));
    check("busy_b", 32'(bus_b.clr_busy), 32'(k != 0));
    check("done_b", 32'(bus_b.clr_done), 32'(k == NREGS + 1));
    last_busy = bus_a.clr_busy;
    last_done = bus_a.clr_done;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // While reset is held: flags low and every register reads zero.
  task automatic reset_check();
    #1;
    check("rst_busy_a", 32'(bus_a.clr_busy), 32'd0);
    check("rst_done_a", 32'(bus_a.clr_done), 32'd0);
    check("rst_busy_b", 32'(bus_b.clr_busy), 32'd0);
    for (int a = 0; a < NREGS; a++) begin
      du_addr = AW'(a);
      #1;
      check("rst_du_a", bus_a.du_data, 32'd0);
      check("rst_du_b", bus_b.du_data, 32'd0);
    end
  endtask

  task automatic fill_all();
    for (int a = 1; a < NREGS; a++) begin
      wa_en = 1'b1; wa_addr = AW'(a); wa_data = $urandom() | 32'd1;
      step();
    end
    idle_inputs();
  endtask

  initial begin
    int busy_cyc, done_cnt, done_at;
    idle_inputs();
    rs_addr = '0; rt_addr = '0; du_addr = '0;
    model_reset();
    #2 rst_n = 1'b0;
    reset_check();
    @(negedge clk);
    rst_n = 1'b1;

    // Write r5 on the first edge after reset, read it back next cycle.
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEADBEEF;
    step();
    idle_inputs();
    rs_addr = 5'd5; du_addr = 5'd5;
    #1;
    check("r5_rs", bus_a.rs_data, 32'hDEADBEEF);
    check("r5_du", bus_a.du_data, 32'hDEADBEEF);
    step();

    // Same-address dual write: port B wins, visible in-cycle through bypass.
    wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h11;
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h22;
    rt_addr = 5'd3;
    #1;
    check("r3_byp", bus_a.rt_data, 32'h22);
    check("r3_nobyp", bus_b.rt_data, 32'h0);
    step();
    idle_inputs();
    #1;
    check("r3_after_a", bus_a.rt_data, 32'h22);
    check("r3_after_b", bus_b.rt_data, 32'h22);
    step();

    // Writes to r0 are dropped, including the in-cycle view.
    wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFFFFFF;
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    rs_addr = 5'd0; rt_addr = 5'd0; du_addr = 5'd0;
    #1;
    check("r0_rs_wr", bus_a.rs_data, 32'd0);
    check("r0_rt_wr", bus_a.rt_data, 32'd0);
    check("r0_du_wr", bus_a.du_data, 32'd0);
    step();
    idle_inputs();
    #1;
    check("r0_rs", bus_a.rs_data, 32'd0);
    check("r0_du", bus_b.du_data, 32'd0);
    step();

    // Without bypass the new value appears one cycle after the write.
    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h33;
    step();
    wa_data = 32'h5A; rs_addr = 5'd7;
    #1;
    check("r7_old_nb", bus_b.rs_data, 32'h33);
    check("r7_byp",    bus_a.rs_data, 32'h5A);
    step();
    idle_inputs();
    #1;
    check("r7_new_nb", bus_b.rs_data, 32'h5A);
    step();

    // Random traffic with address collisions and occasional clears.
    for (int n = 0; n < 600; n++) begin
      wa_en   = 1'($urandom_range(1));
      wb_en   = 1'($urandom_range(1));
      wa_addr = AW'($urandom_range(NREGS - 1));
      wb_addr = ($urandom_range(3) == 0) ? wa_addr : AW'($urandom_range(NREGS - 1));
      wa_data = $urandom();
      wb_data = $urandom();
      rs_addr = ($urandom_range(2) == 0) ? wa_addr : AW'($urandom_range(NREGS - 1));
      rt_addr = ($urandom_range(2) == 0) ? wb_addr : AW'($urandom_range(NREGS - 1));
      du_addr = AW'($urandom_range(NREGS - 1));
      clr_req = ($urandom_range(79) == 0);
      step();
    end
    idle_inputs();
    while (k != 0) step();

    // Full clear: busy span, done timing, lost mid-sweep write, all zero after.
    fill_all();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    busy_cyc = 0; done_cnt = 0; done_at = -1;
    for (int j = 0; j < NREGS + 4; j++) begin
      if (j == 20) begin
        wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hCAFE0001;
      end else begin
        wa_en = 1'b0;
      end
      du_addr = AW'(j % NREGS);
      step();
      if (last_busy) busy_cyc++;
      if (last_done) begin done_cnt++; done_at = j; end
    end
    idle_inputs();
    check("clr_busy_cycles", 32'(busy_cyc), 32'(NREGS + 1));
    check("clr_done_count",  32'(done_cnt), 32'd1);
    check("clr_done_at",     32'(done_at),  32'(NREGS));
    for (int a = 0; a < NREGS; a++) begin
      du_addr = AW'(a); rs_addr = AW'(a);
      #1;
      check("clr_du_zero", bus_a.du_data, 32'd0);
      check("clr_rs_zero", bus_b.rs_data, 32'd0);
    end
    @(negedge clk);

    // Reset mid-sweep at idx=10.
    fill_all();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (10) step();
    du_addr = 5'd12;
    #1;
    check("pre_rst_r12", bus_a.du_data, m[12]);
    rst_n = 1'b0;
    reset_check();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    wa_en = 1'b1; wa_addr = 5'd9; wa_data = 32'h1234;
    step();
    idle_inputs();
    rs_addr = 5'd9;
    #1;
    check("post_rst_r9", bus_a.rs_data, 32'h1234);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32, meaning register data width in bits.
REQ-002 The block SHALL take parameter NREGS, default 32, meaning register count (power of two, 4..256).
REQ-003 The block SHALL take parameter AW, default $clog2(NREGS), meaning address width.
REQ-004 The block SHALL take parameter ZERO_REG, default 1, meaning that register 0 is hardwired to zero when it is 1.
REQ-005 The block SHALL take parameter BYPASS, default 1, meaning that read ports forward same-cycle writes when it is 1.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-007 The block SHALL have the following ports (name, direction, width, meaning):
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous active-low reset.
- rs_addr  input  AW  read port A address.
- rt_addr  input  AW  read port B address.
- rs_data  output  DATA_W  read port A data (combinational).
- rt_data  output  DATA_W  read port B data (combinational).
- wa_en  input  1  write port A enable.
- wa_addr  input  AW  write port A address.
- wa_data  input  DATA_W  write port A data.
- wb_en  input  1  write port B enable.
- wb_addr  input  AW  write port B address.
- wb_data  input  DATA_W  write port B data.
- du_addr  input  AW  debug-unit read address.
- du_data  output  DATA_W  debug-unit read data (combinational, never bypassed).
- clr_req  input  1  request a sequential clear of all registers.
- clr_busy  output  1  clear sweep in progress.
- clr_done  output  1  one-cycle pulse when the sweep completes.

Function
REQ-008 Writes SHALL commit on the rising clk edge when the port enable is 1 and the FSM is in IDLE.
REQ-009 When wa_en and wb_en target the same address in one cycle, port B data SHALL be stored.
REQ-010 With ZERO_REG=1, writes to address 0 SHALL be dropped, and every read of address 0 (rs, rt, du) SHALL return 0.
REQ-011 With BYPASS=1, in IDLE, rs_data/rt_data SHALL return the data of an enabled, non-dropped write to the same address in the same cycle, with port B taking priority over port A.
REQ-012 With BYPASS=0, rs_data/rt_data SHALL return stored contents only; the new value SHALL be visible the cycle after the write.
REQ-013 Reads SHALL have zero latency; they are combinational from the address and register state.
REQ-014 The clear FSM SHALL have three states: IDLE, SWEEP and DONE.
REQ-015 IDLE -> SWEEP SHALL occur on a clk edge where clr_req=1; the sweep index SHALL load 0.
REQ-016 In SWEEP, one register SHALL be zeroed per cycle, register[idx]; idx SHALL increment by 1, and on idx=NREGS-1 the FSM SHALL go to DONE. The sweep SHALL take exactly NREGS cycles.
REQ-017 DONE SHALL last one cycle, assert clr_done=1, then go to IDLE.
REQ-018 clr_busy SHALL be 1 in SWEEP and DONE, and 0 in IDLE.
REQ-019 While clr_busy=1, write ports SHALL be ignored (writes lost, not queued), bypass SHALL be disabled, and clr_req SHALL be ignored.
REQ-020 Reads during the sweep SHALL return current stored contents; already-swept registers read 0.
REQ-021 A clr_req held high in DONE SHALL be ignored; if it is still high in the following IDLE cycle, a new sweep SHALL start.
REQ-022 idx SHALL be AW bits wide; no wrap past NREGS-1 SHALL occur.

Reset
REQ-023 reset=0 SHALL immediately, without a clock, zero all registers, set the FSM to IDLE, set idx=0, and drive clr_busy=0 and clr_done=0.
REQ-024 Assertion of reset mid-sweep SHALL abort the sweep; after release the block SHALL be in IDLE with all registers 0.
REQ-025 The first write SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-026 Bench scenario: write wa r5=0xDEADBEEF, next cycle rs_addr=5 -> rs_data=0xDEADBEEF; du_addr=5 -> du_data=0xDEADBEEF.
REQ-027 Bench scenario: wa r3=0x11, wb r3=0x22 same cycle, rt_addr=3 -> rt_data=0x22 in that cycle (BYPASS=1) and 0x22 afterwards.
REQ-028 Bench scenario: write r0=0xFFFFFFFF with ZERO_REG=1 -> rs/rt/du for address 0 read 0, including during the write cycle.
REQ-029 Bench scenario: fill all registers nonzero, pulse clr_req -> clr_busy high for NREGS+1 cycles, clr_done pulses once NREGS cycles after the request edge, all registers read 0, and a write issued mid-sweep is lost.
REQ-030 Bench scenario: BYPASS=0, write r7=0x5A with rs_addr=7 -> rs_data=old value in the write cycle, 0x5A next cycle.
REQ-031 Bench scenario: assert reset at sweep idx=10 -> clr_busy=0 immediately, all registers 0, and a normal write succeeds after release.
